// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-digit BCD adder, one digit per clock LSD first; define BCD_CHECK_EN for the err port.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry_out
`ifdef BCD_CHECK_EN
  ,
  output logic                err
`endif
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, next_state;
  logic [W-1:0] a_r, b_r, w, w_next;
  logic [IW-1:0] idx;
  logic [4:0] raw;
  logic [3:0] dig;
  logic c, gt9, last, go;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    go = start && state != ADD;
    last = idx == IW'(DIGITS - 1);
    next_state = go ? ADD : state == ADD ? (last ? DONE : ADD) : IDLE;
    busy = state == ADD;
    done = state == DONE;
    raw = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + 5'(c);
    gt9 = raw > 5'd9;
    dig = gt9 ? raw[3:0] + 4'd6 : raw[3:0];
    w_next = (w >> 4) | (W'(dig) << (W - 4));
  end
`ifdef BCD_CHECK_EN
  logic bad_in, bad_r;
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i+:4] > 4'd9 || b[4*i+:4] > 4'd9) bad_in = 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      bad_r <= 1'b0;
      err <= 1'b0;
    end else if (go) bad_r <= bad_in;
    else if (state == ADD && last) err <= bad_r;
`endif
  // Operands shift right so the active digit is always in bits [3:0]; the result fills from the top.
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      w <= '0;
      c <= 1'b0;
      idx <= '0;
      sum <= '0;
      carry_out <= 1'b0;
    end else if (go) begin
      a_r <= a;
      b_r <= b;
      c <= carry_in;
      idx <= '0;
    end else if (state == ADD) begin
      a_r <= a_r >> 4;
      b_r <= b_r >> 4;
      c <= gt9;
      w <= w_next;
      idx <= idx + 1'b1;
      if (last) begin
        sum <= w_next;
        carry_out <= gt9;
      end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed-vector self-checking bench for bcd_serial_adder (DIGITS=4).
module tb_bcd_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, carry_in = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic busy, done, carry_out;
  int tests = 0, fails = 0, lat, bcyc, ndone;
`ifdef BCD_CHECK_EN
  logic err;
`endif
  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
`ifdef BCD_CHECK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_done();
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcyc++;
    end
  endtask
  task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input logic ci);
    a = ta; b = tb_; carry_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    bcyc = busy ? 1 : 0;
    wait_done();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    rst_n = 1'b1;
    run(16'h1234, 16'h5678, 0);
    check("lat", lat, 5);
    check("busy_cycles", bcyc, 4);
    check("sum_1234", sum, 16'h6912);
    check("cout_1234", carry_out, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum", sum, 16'h6912);
    run(16'h9999, 16'h0001, 0);
    check("sum_9999p1", sum, 16'h0000);
    check("cout_9999p1", carry_out, 1);
    run(16'h9999, 16'h9999, 1);
    check("sum_9999x2", sum, 16'h9999);
    check("cout_9999x2", carry_out, 1);
    run(16'h0000, 16'h0000, 1);
    check("sum_cin", sum, 16'h0001);
    check("cout_cin", carry_out, 0);
    run(16'h000F, 16'h0000, 0);
    check("sum_nonbcd", sum, 16'h0015);
    check("cout_nonbcd", carry_out, 0);
    a = 16'h1234; b = 16'h5678; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcyc = 1;
    @(posedge clk); #1;
    lat++;
    a = 16'h1111; b = 16'h1111; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    wait_done();
    check("ign_lat", lat, 5);
    check("ign_sum", sum, 16'h6912);
    check("ign_cout", carry_out, 0);
    run(16'h1111, 16'h1111, 0);
    check("b2b_lat", lat, 5);
    check("b2b_sum", sum, 16'h2222);
    run(16'h4321, 16'h1234, 0);
    run(16'h4321, 16'h1234, 0);
    check("pre_rst_sum", sum, 16'h5555);
    a = 16'h0500; b = 16'h0505; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", carry_out, 0);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);
    run(16'h0500, 16'h0505, 0);
    check("post_rst_lat", lat, 5);
    check("post_rst_sum", sum, 16'h1005);
`ifdef BCD_CHECK_EN
    run(16'h00A0, 16'h0001, 0);
    check("err_set", err, 1);
    check("err_sum", sum, 16'h0101);
    repeat (2) @(posedge clk);
    #1;
    check("err_hold", err, 1);
    run(16'h0001, 16'h0001, 0);
    check("err_clr", err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
